// File: rtl/fp_filt_pkg.sv
// rtl/fp_filt_pkg.sv - shared state encoding and FP helpers for the IIR engine
// Purpose: sequencer state enum, IEEE-754 single constants and the sign-flip helper.
// Ports: none (package).
package fp_filt_pkg;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

  typedef enum logic [3:0] {
    IDLE,
    MUL_ISS,
    MUL_WAIT,
    ADD_ISS,
    ADD_WAIT,
    ERR_ISS,
    ERR_WAIT,
    SQ_ISS,
    SQ_WAIT,
    ACC_ISS,
    ACC_WAIT,
    DONE
  } state_t;

  // Negation is a pure sign-bit flip, so subtraction reuses the adder.
  function automatic logic [31:0] fp_neg(input logic [31:0] v);
    return {~v[31], v[30:0]};
  endfunction

endpackage

// File: rtl/fp_tap_hist.sv
// rtl/fp_tap_hist.sv - depth-N shift register of 32-bit sample words
// Purpose: holds the N most recent words, taps[0] newest; oldest word drops off on shift.
// Ports: clk; clr synchronous clear (wins over shift); shift strobe; din word to push;
//   taps packed view of all N stored words.
module fp_tap_hist #(
  parameter int N = 3
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               shift,
  input  logic [31:0]        din,
  output logic [N-1:0][31:0] taps
);

  always_ff @(posedge clk) begin
    if (clr) begin
      taps <= '0;
    end else if (shift) begin
      taps[0] <= din;
      for (int i = 1; i < N; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

endmodule

// File: rtl/fp_iir_engine.sv
// rtl/fp_iir_engine.sv - single-precision IIR filter sequencer on shared FP mul/add cores
// Purpose: y[n] = x[n] + sum b[k]*x[n-k] + sum a[k]*y[n-k], evaluated one tap at a time.
// Ports: clk, rst (sync, active high); in_valid/in_ready/in_x/in_ref sample stream;
//   out_valid (one-cycle pulse), out_y, out_err, sse results; clear_sse;
//   coef_we/coef_addr/coef_data coefficient port (b[1..NB] then a[1..NA]);
//   mul_*/add_* operand, operation_nd, operation_rfd, result and rdy of the external cores.
// Build option: FP_IIR_SSE_EN adds e[n] = y[n] - r[n] and the running sum of e^2;
//   without it out_err and sse read 0 and clear_sse has no effect.
module fp_iir_engine
  import fp_filt_pkg::*;
#(
  parameter int NB = 3,
  parameter int NA = 1,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_x,
  input  logic [31:0]   in_ref,
  output logic          out_valid,
  output logic [31:0]   out_y,
  output logic [31:0]   out_err,
  output logic [31:0]   sse,
  input  logic          clear_sse,
  input  logic          coef_we,
  input  logic [CW-1:0] coef_addr,
  input  logic [31:0]   coef_data,
  output logic [31:0]   mul_a,
  output logic [31:0]   mul_b,
  output logic          mul_nd,
  input  logic          mul_rfd,
  input  logic [31:0]   mul_res,
  input  logic          mul_rdy,
  output logic [31:0]   add_a,
  output logic [31:0]   add_b,
  output logic          add_nd,
  input  logic          add_rfd,
  input  logic [31:0]   add_res,
  input  logic          add_rdy
);

  localparam int NT  = NB + NA;
  localparam int NYH = (NA > 0) ? NA : 1;

  state_t               state_q, state_d;
  logic [NT-1:0][31:0]  coef;
  logic [NB-1:0][31:0]  x_hist;
  logic [NYH-1:0][31:0] y_hist;
  logic [NT-1:0][31:0]  hist_all;
  logic [CW-1:0]        tap;
  logic [31:0]          x_q, acc, prod, y_q, out_y_q, coef_sel, hist_sel;
  logic                 out_valid_q, last_tap, hist_shift;

`ifdef FP_IIR_SSE_EN
  logic [31:0] ref_q, err_q, out_err_q, sse_q;
  assign out_err = out_err_q;
  assign sse     = sse_q;
`else
  logic [32:0] unused_sse_in;
  assign unused_sse_in = {clear_sse, in_ref};
  assign out_err       = FP_ZERO;
  assign sse           = FP_ZERO;
`endif

  assign out_valid  = out_valid_q;
  assign out_y      = out_y_q;
  assign hist_shift = (state_q == DONE);
  assign last_tap   = (tap == CW'(NT - 1));

  fp_tap_hist #(.N(NB)) u_x_hist (
    .clk(clk), .clr(rst), .shift(hist_shift), .din(x_q), .taps(x_hist)
  );

  fp_tap_hist #(.N(NYH)) u_y_hist (
    .clk(clk), .clr(rst), .shift(hist_shift), .din(y_q), .taps(y_hist)
  );

  // Tap index space matches the coefficient map: x history first, then y history.
  if (NA > 0) begin : g_fb
    assign hist_all = {y_hist, x_hist};
  end else begin : g_ff_only
    assign hist_all = x_hist;
  end

  always_comb begin
    coef_sel = FP_ZERO;
    hist_sel = FP_ZERO;
    for (int i = 0; i < NT; i++) begin
      if (tap == CW'(i)) begin
        coef_sel = coef[i];
        hist_sel = hist_all[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // nd is gated by rfd and the ISS state is left on the same edge, so each
  // operation is requested exactly once.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    mul_nd   = 1'b0;
    add_nd   = 1'b0;
    mul_a    = FP_ZERO;
    mul_b    = FP_ZERO;
    add_a    = FP_ZERO;
    add_b    = FP_ZERO;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = MUL_ISS;
      end
      MUL_ISS: begin
        mul_a = coef_sel;
        mul_b = hist_sel;
        if (mul_rfd) begin
          mul_nd  = 1'b1;
          state_d = MUL_WAIT;
        end
      end
      MUL_WAIT: if (mul_rdy) state_d = ADD_ISS;
      ADD_ISS: begin
        add_a = acc;
        add_b = prod;
        if (add_rfd) begin
          add_nd  = 1'b1;
          state_d = ADD_WAIT;
        end
      end
      ADD_WAIT: begin
        if (add_rdy) begin
`ifdef FP_IIR_SSE_EN
          state_d = last_tap ? ERR_ISS : MUL_ISS;
`else
          state_d = last_tap ? DONE : MUL_ISS;
`endif
        end
      end
`ifdef FP_IIR_SSE_EN
      ERR_ISS: begin
        add_a = y_q;
        add_b = fp_neg(ref_q);
        if (add_rfd) begin
          add_nd  = 1'b1;
          state_d = ERR_WAIT;
        end
      end
      ERR_WAIT: if (add_rdy) state_d = SQ_ISS;
      SQ_ISS: begin
        mul_a = err_q;
        mul_b = err_q;
        if (mul_rfd) begin
          mul_nd  = 1'b1;
          state_d = SQ_WAIT;
        end
      end
      SQ_WAIT: if (mul_rdy) state_d = ACC_ISS;
      ACC_ISS: begin
        add_a = sse_q;
        add_b = prod;
        if (add_rfd) begin
          add_nd  = 1'b1;
          state_d = ACC_WAIT;
        end
      end
      ACC_WAIT: if (add_rdy) state_d = DONE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // prod holds e^2 and acc holds the new SSE once the filter sum is finished.
  always_ff @(posedge clk) begin
    if (rst) begin
      coef        <= '0;
      tap         <= '0;
      x_q         <= FP_ZERO;
      acc         <= FP_ZERO;
      prod        <= FP_ZERO;
      y_q         <= FP_ZERO;
      out_y_q     <= FP_ZERO;
      out_valid_q <= 1'b0;
`ifdef FP_IIR_SSE_EN
      ref_q       <= FP_ZERO;
      err_q       <= FP_ZERO;
      out_err_q   <= FP_ZERO;
      sse_q       <= FP_ZERO;
`endif
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (coef_we) begin
            for (int i = 0; i < NT; i++) begin
              if (coef_addr == CW'(i)) coef[i] <= coef_data;
            end
          end
`ifdef FP_IIR_SSE_EN
          if (clear_sse) sse_q <= FP_ZERO;
          if (in_valid) ref_q <= in_ref;
`endif
          if (in_valid) begin
            x_q <= in_x;
            acc <= in_x;
            tap <= '0;
          end
        end
        MUL_WAIT: if (mul_rdy) prod <= mul_res;
        ADD_WAIT: begin
          if (add_rdy) begin
            acc <= add_res;
            if (last_tap) y_q <= add_res;
            else          tap <= tap + 1'b1;
          end
        end
`ifdef FP_IIR_SSE_EN
        ERR_WAIT: if (add_rdy) err_q <= add_res;
        SQ_WAIT:  if (mul_rdy) prod <= mul_res;
        ACC_WAIT: if (add_rdy) acc <= add_res;
`endif
        DONE: begin
          out_valid_q <= 1'b1;
          out_y_q     <= y_q;
`ifdef FP_IIR_SSE_EN
          out_err_q   <= err_q;
          sse_q       <= acc;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_iir_engine.sv
// tb/tb_fp_iir_engine.sv - self-checking bench for fp_iir_engine with behavioural FP cores
module tb_fp_iir_engine;

  localparam int NB = 3;
  localparam int NA = 1;
  localparam int CW = 4;
  localparam int NT = NB + NA;
`ifdef FP_IIR_SSE_EN
  localparam bit SSE = 1'b1;
`else
  localparam bit SSE = 1'b0;
`endif
  localparam logic [31:0] F0   = 32'h0000_0000;
  localparam logic [31:0] F1   = 32'h3F80_0000;
  localparam logic [31:0] FH   = 32'h3F00_0000;
  localparam logic [31:0] F2   = 32'h4000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, clear_sse = 1'b0, coef_we = 1'b0;
  logic [31:0] in_x = '0, in_ref = '0, coef_data = '0;
  logic [CW-1:0] coef_addr = '0;
  logic in_ready, out_valid, mul_nd, add_nd, mul_rfd, add_rfd;
  logic [31:0] out_y, out_err, sse, mul_a, mul_b, add_a, add_b;
  logic mul_rdy = 1'b0, add_rdy = 1'b0;
  logic [31:0] mul_res = '0, add_res = '0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fp_iir_engine #(.NB(NB), .NA(NA), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .in_ref(in_ref), .out_valid(out_valid), .out_y(out_y), .out_err(out_err), .sse(sse),
    .clear_sse(clear_sse), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .mul_a(mul_a), .mul_b(mul_b), .mul_nd(mul_nd), .mul_rfd(mul_rfd), .mul_res(mul_res),
    .mul_rdy(mul_rdy), .add_a(add_a), .add_b(add_b), .add_nd(add_nd), .add_rfd(add_rfd),
    .add_res(add_res), .add_rdy(add_rdy)
  );

  // ---------------- IEEE-754 single helpers via double arithmetic ----------------
  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:23] == 8'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'h0});
  endfunction

  function automatic logic [31:0] r2f(input real v);
    logic [63:0] d;
    logic [23:0] m;
    logic [28:0] rem;
    int e;
    d = $realtobits(v);
    if (d[62:0] == 63'd0) return 32'h0;
    e = int'(d[62:52]) - 1023 + 127;
    m = {1'b1, d[51:29]};
    rem = d[28:0];
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && m[0])) begin
      if (m == 24'hFF_FFFF) begin m = 24'h80_0000; e++; end
      else m = m + 24'd1;
    end
    if (e <= 0) return 32'h0;
    return {d[63], e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) * f2r(b));
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  // ---------------- behavioural FP cores: 1-8 cycle latency, random rfd gaps ----------------
  logic m_busy = 1'b0, m_gap = 1'b1, mul_hold = 1'b0;
  logic a_busy = 1'b0, a_gap = 1'b1;
  int m_cnt = 0, a_cnt = 0;
  logic [31:0] m_a = '0, m_b = '0, a_a = '0, a_b = '0;

  assign mul_rfd = !m_busy && m_gap && !mul_hold;
  assign add_rfd = !a_busy && a_gap;

  always @(posedge clk) begin
    mul_rdy <= 1'b0;
    m_gap   <= ($urandom_range(0, 3) != 0);
    if (m_busy) begin
      if (m_cnt == 0) begin
        mul_rdy <= 1'b1;
        mul_res <= fmul(m_a, m_b);
        m_busy  <= 1'b0;
      end else m_cnt <= m_cnt - 1;
    end else if (mul_nd && mul_rfd) begin
      m_busy <= 1'b1;
      m_a <= mul_a;
      m_b <= mul_b;
      m_cnt <= int'($urandom_range(0, 7));
    end
  end

  always @(posedge clk) begin
    add_rdy <= 1'b0;
    a_gap   <= ($urandom_range(0, 3) != 0);
    if (a_busy) begin
      if (a_cnt == 0) begin
        add_rdy <= 1'b1;
        add_res <= fadd(a_a, a_b);
        a_busy  <= 1'b0;
      end else a_cnt <= a_cnt - 1;
    end else if (add_nd && add_rfd) begin
      a_busy <= 1'b1;
      a_a <= add_a;
      a_b <= add_b;
      a_cnt <= int'($urandom_range(0, 7));
    end
  end

  // nd must never be raised while the core cannot accept it.
  always @(negedge clk) begin
    if (!rst && mul_nd) begin
      n_checks++;
      if (!mul_rfd) begin n_fail++; $display("FAIL mul_nd_protocol: mul_nd=1 while mul_rfd=%b, want rfd 1", mul_rfd); end
    end
    if (!rst && add_nd) begin
      n_checks++;
      if (!add_rfd) begin n_fail++; $display("FAIL add_nd_protocol: add_nd=1 while add_rfd=%b, want rfd 1", add_rfd); end
    end
  end

  // ---------------- reference model: direct evaluation of the filter equations ----------------
  logic [31:0] mcoef [16];
  logic [31:0] mxh [16];
  logic [31:0] myh [16];
  logic [31:0] msse;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin mcoef[i] = F0; mxh[i] = F0; myh[i] = F0; end
    msse = F0;
  endtask

  task automatic model_step(input logic [31:0] x, input logic [31:0] r,
                            output logic [31:0] y, output logic [31:0] e, output logic [31:0] s);
    logic [31:0] nr;
    y = x;
    for (int k = 0; k < NB; k++) y = fadd(y, fmul(mcoef[k], mxh[k]));
    for (int k = 0; k < NA; k++) y = fadd(y, fmul(mcoef[NB+k], myh[k]));
    nr = r;
    nr[31] = ~nr[31];
    e = fadd(y, nr);
    msse = fadd(msse, fmul(e, e));
    for (int k = 15; k > 0; k--) begin mxh[k] = mxh[k-1]; myh[k] = myh[k-1]; end
    mxh[0] = x;
    myh[0] = y;
    s = msse;
    if (!SSE) begin e = F0; s = F0; end
  endtask

  // ---------------- stimulus drivers (no checking inside) ----------------
  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; clear_sse = 1'b0; coef_we = 1'b0; mul_hold = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 600) begin @(posedge clk); #1; n++; end
  endtask

  task automatic write_coef(input int addr, input logic [31:0] d);
    wait_idle();
    coef_we = 1'b1; coef_addr = CW'(addr); coef_data = d;
    @(posedge clk); #1;
    coef_we = 1'b0;
    if (addr < NT) mcoef[addr] = d;
  endtask

  task automatic launch(input logic [31:0] x, input logic [31:0] r);
    wait_idle();
    in_valid = 1'b1; in_x = x; in_ref = r;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output bit to);
    int n = 0;
    while (!out_valid && n < 600) begin @(posedge clk); #1; n++; end
    to = !out_valid;
  endtask

  task automatic send_sample(input logic [31:0] x, input logic [31:0] r, output logic [31:0] y,
                             output logic [31:0] e, output logic [31:0] s, output bit to);
    launch(x, r);
    wait_done(to);
    y = out_y; e = out_err; s = sse;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_y !== F0) begin n_fail++; $display("FAIL reset_out_y: got %h want 0", out_y); end
    n_checks++; if (out_err !== F0) begin n_fail++; $display("FAIL reset_out_err: got %h want 0", out_err); end
    n_checks++; if (sse !== F0) begin n_fail++; $display("FAIL reset_sse: got %h want 0", sse); end
    n_checks++; if ({mul_nd, add_nd} !== 2'b00) begin n_fail++; $display("FAIL reset_nd: got %b want 00", {mul_nd, add_nd}); end
  endtask

  task automatic test_passthrough();
    logic [31:0] y, e, s; bit to;
    do_reset();
    send_sample(F1, F1, y, e, s, to);
    n_checks++; if (to || y !== F1) begin n_fail++; $display("FAIL pass_y: got %h want %h (timeout %b)", y, F1, to); end
    n_checks++; if (e !== F0) begin n_fail++; $display("FAIL pass_err: got %h want 0", e); end
    n_checks++; if (s !== F0) begin n_fail++; $display("FAIL pass_sse: got %h want 0", s); end
  endtask

  task automatic test_impulse(input bit feedback);
    logic [31:0] y, e, s; bit to;
    logic [31:0] xs [4];
    logic [31:0] ey [4];
    xs = '{F1, F0, F0, F0};
    if (feedback) ey = '{F1, FH, 32'h3E80_0000, 32'h3E00_0000};
    else          ey = '{F1, FH, F0, F0};
    do_reset();
    write_coef(feedback ? NB : 0, FH);
    for (int i = 0; i < 4; i++) begin
      send_sample(xs[i], F0, y, e, s, to);
      n_checks++;
      if (to || y !== ey[i]) begin n_fail++; $display("FAIL impulse%0d_y%0d: got %h want %h (timeout %b)", feedback, i, y, ey[i], to); end
    end
    if (!feedback) begin
      n_checks++;
      if (s !== (SSE ? 32'h3FA0_0000 : F0)) begin n_fail++; $display("FAIL impulse_sse: got %h want %h", s, SSE ? 32'h3FA0_0000 : F0); end
    end
  endtask

  task automatic test_sse_clear();
    logic [31:0] y, e, s; bit to;
    do_reset();
    send_sample(F2, F0, y, e, s, to);
    send_sample(F2, F0, y, e, s, to);
    n_checks++; if (to || s !== (SSE ? 32'h4100_0000 : F0)) begin n_fail++; $display("FAIL sse_two: got %h want %h", s, SSE ? 32'h4100_0000 : F0); end
    n_checks++; if (e !== (SSE ? F2 : F0)) begin n_fail++; $display("FAIL sse_err: got %h want %h", e, SSE ? F2 : F0); end
    // clear_sse and coef_we while busy must be dropped
    launch(F2, F0);
    clear_sse = 1'b1; coef_we = 1'b1; coef_addr = CW'(0); coef_data = F1;
    repeat (3) begin @(posedge clk); #1; end
    clear_sse = 1'b0; coef_we = 1'b0;
    wait_done(to);
    n_checks++; if (to || sse !== (SSE ? 32'h4140_0000 : F0)) begin n_fail++; $display("FAIL sse_busy_clear: got %h want %h", sse, SSE ? 32'h4140_0000 : F0); end
    clear_sse = 1'b1;
    @(posedge clk); #1;
    clear_sse = 1'b0;
    n_checks++; if (sse !== F0) begin n_fail++; $display("FAIL sse_idle_clear: got %h want 0", sse); end
    send_sample(F2, F0, y, e, s, to);
    n_checks++; if (to || y !== F2) begin n_fail++; $display("FAIL busy_coef_dropped_y: got %h want %h", y, F2); end
    n_checks++; if (s !== (SSE ? 32'h4080_0000 : F0)) begin n_fail++; $display("FAIL sse_after_clear: got %h want %h", s, SSE ? 32'h4080_0000 : F0); end
    write_coef(15, F1);
    send_sample(F2, F0, y, e, s, to);
    n_checks++; if (to || y !== F2) begin n_fail++; $display("FAIL bad_addr_ignored_y: got %h want %h", y, F2); end
  endtask

  task automatic test_rfd_stall();
    logic [31:0] y, e, s; bit to;
    do_reset();
    write_coef(0, FH);
    mul_hold = 1'b1;
    launch(F1, F0);
    in_valid = 1'b1; in_x = 32'h4080_0000;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (mul_nd !== 1'b0) begin n_fail++; $display("FAIL stall_mul_nd%0d: got %b want 0", i, mul_nd); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready%0d: got %b want 0", i, in_ready); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    mul_hold = 1'b0;
    wait_done(to);
    n_checks++; if (to || out_y !== F1) begin n_fail++; $display("FAIL stall_y: got %h want %h (timeout %b)", out_y, F1, to); end
    send_sample(F0, F0, y, e, s, to);
    n_checks++; if (to || y !== FH) begin n_fail++; $display("FAIL stall_next_y: got %h want %h", y, FH); end
  endtask

  task automatic test_same_cycle_coef();
    logic [31:0] y, e, s; bit to;
    do_reset();
    send_sample(F1, F0, y, e, s, to);
    wait_idle();
    coef_we = 1'b1; coef_addr = CW'(0); coef_data = FH;
    in_valid = 1'b1; in_x = F0; in_ref = F0;
    @(posedge clk); #1;
    coef_we = 1'b0; in_valid = 1'b0;
    wait_done(to);
    n_checks++; if (to || out_y !== FH) begin n_fail++; $display("FAIL same_cycle_coef_y: got %h want %h", out_y, FH); end
    n_checks++; if (sse !== (SSE ? 32'h3FA0_0000 : F0)) begin n_fail++; $display("FAIL same_cycle_sse: got %h want %h", sse, SSE ? 32'h3FA0_0000 : F0); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] y, e, s; bit to, seen; int n;
    logic [31:0] ey [4];
    ey = '{F1, FH, F0, F0};
    do_reset();
    write_coef(0, FH);
    send_sample(F1, F0, y, e, s, to);
    launch(32'h4040_0000, F0);
    n = 0;
    while (!add_nd && n < 600) begin @(posedge clk); #1; n++; end
    n_checks++; if (add_nd !== 1'b1) begin n_fail++; $display("FAIL abort_reach_add: got add_nd %b want 1", add_nd); end
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; seen |= out_valid; end
    rst = 1'b0;
    repeat (10) begin @(posedge clk); #1; seen |= out_valid; end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_out_valid: got %b want 0", seen); end
    n_checks++; if (out_y !== F0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_state: out_y %h in_ready %b want 0/1", out_y, in_ready); end
    model_reset();
    write_coef(0, FH);
    for (int i = 0; i < 4; i++) begin
      send_sample(i == 0 ? F1 : F0, F0, y, e, s, to);
      n_checks++;
      if (to || y !== ey[i]) begin n_fail++; $display("FAIL abort_impulse_y%0d: got %h want %h (timeout %b)", i, y, ey[i], to); end
    end
    n_checks++; if (s !== (SSE ? 32'h3FA0_0000 : F0)) begin n_fail++; $display("FAIL abort_impulse_sse: got %h want %h", s, SSE ? 32'h3FA0_0000 : F0); end
  endtask

  task automatic test_random();
    logic [31:0] x, r, y, e, s, my, me, ms; bit to;
    do_reset();
    for (int i = 0; i < NT; i++) write_coef(i, r2f((real'($urandom_range(0, 16)) - 8.0) / 16.0));
    for (int i = 0; i < 12; i++) begin
      x = r2f((real'($urandom_range(0, 32)) - 16.0) / 8.0);
      r = r2f((real'($urandom_range(0, 32)) - 16.0) / 8.0);
      model_step(x, r, my, me, ms);
      send_sample(x, r, y, e, s, to);
      n_checks++; if (to || y !== my) begin n_fail++; $display("FAIL rand_y%0d: got %h want %h (timeout %b)", i, y, my, to); end
      n_checks++; if (e !== me) begin n_fail++; $display("FAIL rand_err%0d: got %h want %h", i, e, me); end
      n_checks++; if (s !== ms) begin n_fail++; $display("FAIL rand_sse%0d: got %h want %h", i, s, ms); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_passthrough();
    test_impulse(1'b0);
    test_impulse(1'b1);
    test_sse_clear();
    test_rfd_stall();
    test_same_cycle_coef();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_iir_engine.md
Name: fp_iir_engine

Overview:
- Parametrised single-precision floating-point IIR filter sequencer; successor to the fixed 3-tap hard-coded filter FSM.
- Runtime-loadable coefficients, configurable feedforward/feedback tap counts, streaming sample handshake, per-sample error and square-sum-error (SSE) against a reference stream.
- Time-shares one external FP multiplier and one external FP adder core through their operation_nd/operation_rfd/rdy handshakes.
- Sits between the sample/reference memories and the display/readout logic.

Parameters:
- NB, 3, feedforward taps on past inputs x[n-1..n-NB] (1..15)
- NA, 1, feedback taps on past outputs y[n-1..n-NA] (0..15)
- CW, 4, coefficient address width; must satisfy 2^CW >= NB+NA

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- in_valid  in  1  sample x/ref present
- in_ready  out  1  engine idle, accepts sample
- in_x  in  32  input sample x[n], IEEE-754 single
- in_ref  in  32  reference output r[n]
- out_valid  out  1  one-cycle pulse, results valid
- out_y  out  32  y[n]
- out_err  out  32  e[n] = y[n] - r[n]
- sse  out  32  running sum of e^2
- clear_sse  in  1  zero sse (idle only)
- coef_we  in  1  coefficient write strobe
- coef_addr  in  CW  0..NB-1 -> b[1..NB]; NB..NB+NA-1 -> a[1..NA]
- coef_data  in  32  coefficient value
- mul_a, mul_b  out  32  multiplier operands
- mul_nd  out  1  multiplier operation_nd
- mul_rfd  in  1  multiplier operation_rfd
- mul_res  in  32  multiplier result
- mul_rdy  in  1  multiplier rdy
- add_a, add_b  out  32  adder operands
- add_nd  out  1  adder operation_nd
- add_rfd  in  1  adder operation_rfd
- add_res  in  32  adder result
- add_rdy  in  1  adder rdy

Behaviour:
- Function: y[n] = x[n] + sum b[k]*x[n-k] + sum a[k]*y[n-k]; e[n] = y[n] - r[n]; sse += e[n]^2.
- Reset: all outputs 0 except in_ready = 1; x/y history, coefficients, sse, accumulator = 0; FSM to IDLE. Reset mid-operation aborts the sample with no out_valid. Any in-flight FP core result is ignored: the FSM only samples rdy while in a WAIT state it entered after reset.
- States: IDLE, MUL_ISS, MUL_WAIT, ADD_ISS, ADD_WAIT, ERR_ISS, ERR_WAIT, SQ_ISS, SQ_WAIT, ACC_ISS, ACC_WAIT, DONE.
  - IDLE: in_ready = 1. in_valid captures x and ref, acc <= x, tap <= 0, go to MUL_ISS. If NB+NA = 0, go to ERR_ISS.
  - MUL_ISS: waits for mul_rfd. Drives coef[tap] with x_hist[tap] (tap < NB) or y_hist[tap-NB]; pulses mul_nd for one cycle.
  - MUL_WAIT: on mul_rdy, latch product, go to ADD_ISS.
  - ADD_ISS: waits for add_rfd. Drives acc + product; pulses add_nd.
  - ADD_WAIT: on add_rdy, acc <= add_res. Next tap, or y <= acc and go to ERR_ISS after the last tap.
  - ERR_ISS: adds y and {~ref[31], ref[30:0]} (sign flip; no multiply).
  - SQ_ISS: computes e*e.
  - ACC_ISS: computes sse + e^2.
  - DONE: update sse; shift histories (x_hist[0] <= x, y_hist[0] <= y, oldest dropped); out_valid = 1 for one cycle; return to IDLE.
- Handshake rules:
  - nd is never asserted while the matching rfd is low, and never twice for one operation.
  - rdy is sampled only in WAIT states.
  - out_y/out_err hold until the next DONE.
- Minimum latency per sample, with single-cycle FP cores: 2 + 4*(NB+NA) + 6 cycles, excluding core latency.
- coef_we and clear_sse act only in IDLE; otherwise they are dropped silently. Out-of-range coef_addr is ignored. If coef_we and in_valid arrive in the same IDLE cycle, the write takes effect first and the new coefficient is used.

Optional Feature:
- FP_IIR_SSE_EN defined: error, square and accumulate states are present as described.
- Undefined: ERR/SQ/ACC states are removed; ADD_WAIT on the last tap goes to DONE; out_err and sse are tied to 0; clear_sse is ignored.

Decomposition:
- Shared package fp_filt_pkg holds the state enum, FP constants (FP_ZERO=32'h0, FP_ONE=32'h3F800000) and the sign-flip function.
- One sub-module, fp_tap_hist: a parametrised depth-N shift register of 32-bit words with a synchronous clear and a shift strobe. It is instantiated twice, once for x history and once for y history.

Test Plan:
- Bench uses behavioural FP cores with random 1-8 cycle latency and random rfd gaps.
- Coefs all 0, x=3F800000, ref=3F800000 -> out_y=3F800000, out_err=00000000, sse=00000000.
- b[1]=3F000000, impulse x=1.0 then 0,0,0 (ref=0) -> out_y = 3F800000, 3F000000, 0, 0; sse = 3FA00000 (1.25).
- NA=1, a[1]=3F000000, impulse -> out_y = 3F800000, 3F000000, 3E800000, 3E000000.
- Coefs 0, x=40000000, ref=0, two samples -> sse=41000000 (8.0); clear_sse in IDLE -> sse=0. clear_sse while busy -> no change.
- Hold mul_rfd low 5 cycles in MUL_ISS -> mul_nd stays 0, in_ready stays 0, in_valid ignored; result unchanged after release.
- Assert rst during ADD_WAIT, then issue a sample -> no out_valid from the aborted sample; histories zeroed; next impulse reproduces scenario 2 exactly.
